// File: rtl/aes_uart_host.sv
`default_nettype none
// ============================================================================
//  Module      : aes_uart_host
//  Description : Byte-serial host for a UART-attached AES engine. On start it
//                captures the key and plaintext. If requested it sends the 16
//                key bytes, then it sends the 16 plaintext bytes, byte 0
//                first. A fixed idle gap follows every byte. It then collects
//                the 16 ciphertext bytes returned by the engine. A stalled
//                response ends the transaction with a sticky timeout flag.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk          in   1  sole clock, rising edge
//    reset        in   1  asynchronous, active-low
//    start        in   1  transaction request, sampled only when idle
//    send_key     in   1  1 = key then plaintext, 0 = plaintext only
//    key          in   N  AES key, byte i at key[i*8 +: 8]
//    plaintext    in   N  block to encrypt, byte i at plaintext[i*8 +: 8]
//    tx_ready     in   1  byte transmitter idle
//    tx_start     out  1  byte transmit request
//    tx_data      out  8  byte presented to the transmitter
//    rx_valid     in   1  receiver valid level, rising edge = new byte
//    rx_data      in   8  received byte
//    busy         out  1  high whenever not idle
//    done         out  1  one-cycle pulse, ciphertext complete
//    ciphertext   out  N  response, byte i at ciphertext[i*8 +: 8]
//    timeout_err  out  1  sticky, cleared by the next accepted start
// ============================================================================
module aes_uart_host #(
  parameter int N              = 128,
  parameter int GAP_CYCLES     = 1000,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         send_key,
  input  logic [N-1:0] key,
  input  logic [N-1:0] plaintext,
  input  logic         tx_ready,
  output logic         tx_start,
  output logic [7:0]   tx_data,
  input  logic         rx_valid,
  input  logic [7:0]   rx_data,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] ciphertext,
  output logic         timeout_err
);

  localparam int c_NUM_FRAMES = N / 8;
  localparam int c_CNT_W      = $clog2(c_NUM_FRAMES + 1);
  localparam int c_GAP_RAW_W  = $clog2(GAP_CYCLES + 1);
  localparam int c_GAP_W      = (c_GAP_RAW_W > 10) ? c_GAP_RAW_W : 10;
  localparam int c_TO_RAW_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam int c_TO_W       = (c_TO_RAW_W > 21) ? c_TO_RAW_W : 21;

  localparam logic [c_CNT_W-1:0] c_ALL_FRAMES = c_CNT_W'(c_NUM_FRAMES);
  localparam logic [c_CNT_W-1:0] c_LAST_FRAME = c_CNT_W'(c_NUM_FRAMES - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE    = c_CNT_W'(1);
  localparam logic [c_GAP_W-1:0] c_GAP_END    = c_GAP_W'(GAP_CYCLES);
  localparam logic [c_GAP_W-1:0] c_GAP_ONE    = c_GAP_W'(1);
  localparam logic [c_TO_W-1:0]  c_TO_END     = c_TO_W'(TIMEOUT_CYCLES);
  localparam logic [c_TO_W-1:0]  c_TO_ONE     = c_TO_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_TX_ISSUE   = 3'd1,
    ST_TX_BUSY    = 3'd2,
    ST_TX_GAP     = 3'd3,
    ST_RX_COLLECT = 3'd4,
    ST_DONE       = 3'd5
  } state_t;

  state_t               r_state;
  state_t               w_next_state;
  logic [N-1:0]         r_key;
  logic [N-1:0]         r_pt;
  logic [N-1:0]         r_ct;
  logic                 r_phase_key;   // 1 = sending key bytes, 0 = plaintext
  logic [c_CNT_W-1:0]   r_tx_cnt;
  logic [c_CNT_W-1:0]   r_rx_cnt;
  logic [c_GAP_W-1:0]   r_gap_cnt;
  logic [c_TO_W-1:0]    r_to_cnt;
  logic                 r_tx_start;
  logic [7:0]           r_tx_data;
  logic                 r_tx_fell;     // transmitter has accepted the byte
  logic                 r_rx_valid_q;
  logic                 r_timeout_err;
  logic                 w_capture;
  logic                 w_gap_end;
  logic                 w_to_end;
  logic [7:0]           w_tx_byte;
  logic                 w_busy;
  logic                 w_done;

  assign w_capture = (r_state == ST_RX_COLLECT) && rx_valid && !r_rx_valid_q;
  assign w_gap_end = (r_gap_cnt == c_GAP_END);
  assign w_to_end  = (r_to_cnt == c_TO_END);

  // Byte selected by the current phase and transmit index.
  always_comb begin
    w_tx_byte = 8'h00;
    for (int i = 0; i < c_NUM_FRAMES; i++) begin
      if (r_tx_cnt == c_CNT_W'(i)) begin
        w_tx_byte = r_phase_key ? r_key[i*8 +: 8] : r_pt[i*8 +: 8];
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decision and state-decoded outputs
  always_comb begin
    w_next_state = r_state;
    w_busy       = 1'b1;
    w_done       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_busy = 1'b0;
        if (start) w_next_state = ST_TX_ISSUE;
      end
      ST_TX_ISSUE: begin
        if (tx_ready) w_next_state = ST_TX_BUSY;
      end
      ST_TX_BUSY: begin
        if (r_tx_fell && tx_ready) w_next_state = ST_TX_GAP;
      end
      ST_TX_GAP: begin
        if (w_gap_end) begin
          // A finished key phase rolls straight into the plaintext phase.
          if ((r_tx_cnt < c_ALL_FRAMES) || r_phase_key) begin
            w_next_state = ST_TX_ISSUE;
          end else begin
            w_next_state = ST_RX_COLLECT;
          end
        end
      end
      ST_RX_COLLECT: begin
        if (w_capture && (r_rx_cnt == c_LAST_FRAME)) begin
          w_next_state = ST_DONE;
        end else if (!w_capture && w_to_end) begin
          w_next_state = ST_IDLE;
        end
      end
      ST_DONE: begin
        w_done       = 1'b1;
        w_next_state = ST_IDLE;
      end
      default: begin
        w_busy       = 1'b0;
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Datapath: capture registers, counters, transmit handshake, response
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_key         <= '0;
      r_pt          <= '0;
      r_ct          <= '0;
      r_phase_key   <= 1'b0;
      r_tx_cnt      <= '0;
      r_rx_cnt      <= '0;
      r_gap_cnt     <= '0;
      r_to_cnt      <= '0;
      r_tx_start    <= 1'b0;
      r_tx_data     <= 8'h00;
      r_tx_fell     <= 1'b0;
      r_rx_valid_q  <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_rx_valid_q <= rx_valid;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_key         <= key;
            r_pt          <= plaintext;
            r_phase_key   <= send_key;
            r_timeout_err <= 1'b0;
            r_tx_cnt      <= '0;
            r_rx_cnt      <= '0;
            r_gap_cnt     <= '0;
            r_to_cnt      <= '0;
            r_tx_fell     <= 1'b0;
          end
        end
        ST_TX_ISSUE: begin
          if (tx_ready) begin
            r_tx_start <= 1'b1;
            r_tx_data  <= w_tx_byte;
            r_tx_fell  <= 1'b0;
          end
        end
        ST_TX_BUSY: begin
          // Request is held until the transmitter goes busy, then the byte
          // is complete once it reports idle again.
          if (!r_tx_fell) begin
            if (!tx_ready) begin
              r_tx_start <= 1'b0;
              r_tx_fell  <= 1'b1;
            end
          end else if (tx_ready) begin
            r_tx_fell <= 1'b0;
            r_tx_cnt  <= r_tx_cnt + c_CNT_ONE;
            r_gap_cnt <= '0;
          end
        end
        ST_TX_GAP: begin
          if (w_gap_end) begin
            r_gap_cnt <= '0;
            if (r_tx_cnt == c_ALL_FRAMES) begin
              if (r_phase_key) begin
                r_phase_key <= 1'b0;
                r_tx_cnt    <= '0;
              end else begin
                r_to_cnt <= '0;
              end
            end
          end else begin
            r_gap_cnt <= r_gap_cnt + c_GAP_ONE;
          end
        end
        ST_RX_COLLECT: begin
          if (w_capture) begin
            r_rx_cnt <= r_rx_cnt + c_CNT_ONE;
            r_to_cnt <= '0;
          end else if (w_to_end) begin
            r_timeout_err <= 1'b1;
          end else begin
            r_to_cnt <= r_to_cnt + c_TO_ONE;
          end
        end
        default: begin
        end
      endcase

      for (int i = 0; i < c_NUM_FRAMES; i++) begin
        if (w_capture && (r_rx_cnt == c_CNT_W'(i))) begin
          r_ct[i*8 +: 8] <= rx_data;
        end
      end
    end
  end

  assign tx_start    = r_tx_start;
  assign tx_data     = r_tx_data;
  assign busy        = w_busy;
  assign done        = w_done;
  assign ciphertext  = r_ct;
  assign timeout_err = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_aes_uart_host.sv
`default_nettype none
// ============================================================================
//  Module      : tb_aes_uart_host
//  Description : Directed bench for aes_uart_host with a byte transmitter
//                model, an expected-byte scoreboard and a receiver driver.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_uart_host;

  localparam int N    = 128;
  localparam int NF   = 16;
  localparam int GAP  = 20;
  localparam int TMO  = 400;
  localparam int BUSY = 4;

  logic         clk       = 1'b0;
  logic         reset     = 1'b0;
  logic         start     = 1'b0;
  logic         send_key  = 1'b0;
  logic [N-1:0] key       = '0;
  logic [N-1:0] plaintext = '0;
  logic         tx_ready  = 1'b1;
  logic         tx_start;
  logic [7:0]   tx_data;
  logic         rx_valid  = 1'b0;
  logic [7:0]   rx_data   = 8'h00;
  logic         busy;
  logic         done;
  logic [N-1:0] ciphertext;
  logic         timeout_err;

  aes_uart_host #(
    .N              (N),
    .GAP_CYCLES     (GAP),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .send_key    (send_key),
    .key         (key),
    .plaintext   (plaintext),
    .tx_ready    (tx_ready),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .busy        (busy),
    .done        (done),
    .ciphertext  (ciphertext),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int done_total = 0;
  int tx_bytes   = 0;
  int last_done  = 0;
  int txn_cyc    = 0;
  logic [7:0] sb[$];

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (done === 1'b1) done_total <= done_total + 1;

  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Transmitter model: accepts a request, stays busy a few cycles, then
  // reports idle. Each accepted byte is popped from the scoreboard.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (tx_start === 1'b1 && tx_ready === 1'b1) begin
        tx_bytes++;
        chk("tx_byte_expected", (sb.size() > 0), 1);
        if (sb.size() > 0) chk("tx_byte_value", tx_data, sb.pop_front());
        if (last_done > txn_cyc) chk("tx_gap_len", ((cyc - last_done) >= GAP), 1);
        tx_ready = 1'b0;
        repeat (BUSY) @(posedge clk);
        #1;
        chk("tx_start_dropped", tx_start, 0);
        tx_ready  = 1'b1;
        last_done = cyc;
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog observed=hang expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_txn(input logic sk, input logic [N-1:0] k, input logic [N-1:0] p);
    if (sk) for (int i = 0; i < NF; i++) sb.push_back(k[i*8 +: 8]);
    for (int i = 0; i < NF; i++) sb.push_back(p[i*8 +: 8]);
    txn_cyc   = cyc;
    key       = k;
    plaintext = p;
    send_key  = sk;
    start     = 1'b1;
    tick(1);
    start     = 1'b0;
  endtask

  task automatic wait_tx_idle(input string tag);
    int n = 0;
    while ((sb.size() != 0 || tx_ready !== 1'b1) && n < 5000) begin
      tick(1);
      n++;
    end
    chk({tag, "_tx_drain"}, (n < 5000), 1);
    tick(GAP + 10);
  endtask

  task automatic rx_send(input logic [7:0] b, input int hold);
    rx_data  = b;
    rx_valid = 1'b1;
    tick(hold);
    rx_valid = 1'b0;
    tick(3);
  endtask

  task automatic wait_done(input string tag, input int d0);
    int n = 0;
    while (done_total == d0 && n < 200) begin
      tick(1);
      n++;
    end
    tick(2);
    chk({tag, "_done_once"}, done_total - d0, 1);
    chk({tag, "_busy_after"}, busy, 0);
  endtask

  logic [N-1:0] key_v, pt_v, pt2_v, ct1_v, ct2_v, ct3_v;
  logic [7:0]   ct1_b[NF];
  int           b0, d0, n;

  initial begin
    ct1_b = '{8'h69, 8'hc4, 8'he0, 8'hd8, 8'h6a, 8'h7b, 8'h04, 8'h30,
              8'hd8, 8'hcd, 8'hb7, 8'h80, 8'h70, 8'hb4, 8'hc5, 8'h5a};
    for (int i = 0; i < NF; i++) begin
      key_v[i*8 +: 8] = 8'(i);
      pt_v[i*8 +: 8]  = 8'(i * 17);
      pt2_v[i*8 +: 8] = 8'(8'hf0 - i);
      ct1_v[i*8 +: 8] = ct1_b[i];
      ct2_v[i*8 +: 8] = 8'(i * 7 + 3);
      ct3_v[i*8 +: 8] = (i < 10) ? 8'(8'ha0 + i) : ct2_v[i*8 +: 8];
    end

    // Reset values
    tick(3);
    chk("rst_tx_start", tx_start, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ciphertext", ciphertext, 0);
    chk("rst_timeout_err", timeout_err, 0);
    reset = 1'b1;
    tick(2);

    // Key + plaintext transaction with port changes, start while busy and
    // stray receiver edges during transmission
    b0 = tx_bytes;
    d0 = done_total;
    start_txn(1'b1, key_v, pt_v);
    chk("busy_after_start", busy, 1);
    key       = ~key_v;
    plaintext = 128'hdeadbeef_cafef00d_01234567_89abcdef;
    tick(30);
    start    = 1'b1;
    send_key = 1'b0;
    tick(1);
    start    = 1'b0;
    rx_data  = 8'hee;
    rx_valid = 1'b1;
    tick(2);
    rx_valid = 1'b0;
    tick(40);
    rx_data  = 8'h77;
    rx_valid = 1'b1;
    tick(1);
    rx_valid = 1'b0;
    wait_tx_idle("key_txn");
    chk("key_txn_ct_untouched", ciphertext, 0);
    chk("key_txn_byte_count", tx_bytes - b0, 32);
    chk("key_txn_done_early", done_total - d0, 0);
    for (int i = 0; i < NF; i++) rx_send(ct1_b[i], 2);
    wait_done("key_txn", d0);
    chk("key_txn_ct", ciphertext, ct1_v);
    chk("key_txn_ct_lo", ciphertext[7:0], 8'h69);
    chk("key_txn_ct_hi", ciphertext[127:120], 8'h5a);
    chk("key_txn_no_err", timeout_err, 0);

    // Plaintext-only transaction, receiver holds each valid level 50 cycles
    b0 = tx_bytes;
    d0 = done_total;
    start_txn(1'b0, key_v, pt2_v);
    wait_tx_idle("pt_txn");
    chk("pt_txn_byte_count", tx_bytes - b0, 16);
    for (int i = 0; i < NF; i++) rx_send(ct2_v[i*8 +: 8], 50);
    wait_done("pt_txn", d0);
    chk("pt_txn_ct", ciphertext, ct2_v);

    // Response stalls after 10 bytes
    d0 = done_total;
    start_txn(1'b0, key_v, pt_v);
    wait_tx_idle("tmo_txn");
    for (int i = 0; i < 10; i++) rx_send(ct3_v[i*8 +: 8], 2);
    n = 0;
    while (busy === 1'b1 && n < TMO + 100) begin
      tick(1);
      n++;
    end
    chk("tmo_latency_min", (n >= TMO - 10), 1);
    chk("tmo_latency_max", (n < TMO + 100), 1);
    chk("tmo_err", timeout_err, 1);
    chk("tmo_busy", busy, 0);
    chk("tmo_no_done", done_total - d0, 0);
    chk("tmo_partial_ct", ciphertext, ct3_v);

    // New start clears the error; reset during the 5th key byte aborts
    start_txn(1'b1, key_v, pt_v);
    tick(1);
    chk("err_cleared_on_start", timeout_err, 0);
    n = 0;
    while (sb.size() > 27 && n < 2000) begin
      tick(1);
      n++;
    end
    chk("reach_5th_byte", (n < 2000), 1);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_tx_start", tx_start, 0);
    chk("mid_rst_tx_data", tx_data, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_ciphertext", ciphertext, 0);
    chk("mid_rst_timeout_err", timeout_err, 0);
    sb.delete();
    tick(3);
    reset = 1'b1;
    b0 = tx_bytes;
    tick(60);
    chk("no_tx_after_reset", tx_bytes - b0, 0);

    // Full restart from key byte 0
    b0 = tx_bytes;
    d0 = done_total;
    start_txn(1'b1, key_v, pt_v);
    wait_tx_idle("restart_txn");
    chk("restart_byte_count", tx_bytes - b0, 32);
    for (int i = 0; i < NF; i++) rx_send(ct1_b[i], 3);
    wait_done("restart_txn", d0);
    chk("restart_ct", ciphertext, ct1_v);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
